// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg
// Shared definitions for the seven-segment reader path:
//   - SEG_CODES      : active-low gfedcba patterns for hex digits 0..F
//   - state_t        : reader FSM states (IDLE, TRACK, HELD)
//   - pattern_to_hex : pattern lookup returning {hit, nibble}
package sevenseg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HELD  = 2'd2
    } state_t;

    // Index k holds the active-low segment pattern (bit 6 = g, bit 0 = a) for hex digit k.
    localparam logic [6:0] SEG_CODES [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Returns {1'b1, digit} for a known pattern, {1'b0, 4'h0} otherwise.
    function automatic logic [4:0] pattern_to_hex(input logic [6:0] pattern);
        logic [4:0] result;
        result = 5'b0_0000;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_CODES[i]) begin
                result = {1'b1, i[3:0]};
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sevenseg_match.sv
// sevenseg_match
// Combinational lookup of an active-low seven-segment pattern into a hex nibble.
// Ports:
//   pattern : input  [6:0] active-low segments, bit 6 = g ... bit 0 = a
//   hit     : output       pattern is one of the sixteen hex codes
//   nibble  : output [3:0] decoded digit (0 when hit is low)
module sevenseg_match
    import sevenseg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       hit,
    output logic [3:0] nibble
);

    logic [4:0] lookup_s;

    assign lookup_s = pattern_to_hex(pattern);
    assign hit      = lookup_s[4];
    assign nibble   = lookup_s[3:0];

endmodule

// File: rtl/sevenseg_reader.sv
// sevenseg_reader
// Reads a multiplexed active-low seven-segment bus back into hex digits. Each
// (segment, anode) sample must be stable for STABLE_CYCLES registered samples
// before the digit is captured; once every digit slot has been captured the
// frame is offered on a valid/ready handshake.
// Ports:
//   clock       : input              rising-edge clock
//   reset       : input              synchronous active-high reset
//   seg_n       : input  [6:0]       segment lines, active low (bit 6 = g, bit 0 = a)
//   an_n        : input  [NDIG-1:0]  digit enables, active low, one-hot-low or all high
//   value       : output [4*NDIG-1:0] captured frame, digit k in value[4k+3:4k]
//   valid       : output             value holds an unconsumed frame
//   ready       : input              consumer accepts value when valid && ready
//   err_pattern : output             one-cycle pulse, a stable pattern matched no hex code
//   err_anode   : output             one-cycle pulse on entering a multi-anode condition
//   overrun     : output             sticky, a frame completed while valid && !ready
module sevenseg_reader
    import sevenseg_pkg::*;
#(
    parameter int NDIG          = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [6:0]        seg_n,
    input  logic [NDIG-1:0]   an_n,
    output logic [4*NDIG-1:0] value,
    output logic              valid,
    input  logic              ready,
    output logic              err_pattern,
    output logic              err_anode,
    output logic              overrun
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Input stage and stability tracking
    logic [6:0]        seg_r;
    logic [NDIG-1:0]   an_r;
    logic [CW-1:0]     cnt_r;
    logic              changed_r;
    logic              an_bad_r;
    logic              changed_s;

    // Anode classification of the registered sample
    logic [NDIG-1:0]   active_s;
    logic [3:0]        low_cnt_s;
    logic [IW-1:0]     idx_s;
    logic              one_hot_s;
    logic              multi_s;

    // Pattern lookup
    logic              hit_s;
    logic [3:0]        nibble_s;

    // FSM
    state_t            state_r;
    state_t            state_next_s;
    logic              cap_en_s;
    logic              err_pat_s;

    // Frame assembly
    logic [NDIG-1:0]   mask_r;
    logic [NDIG-1:0]   mask_next_s;
    logic [NDIG-1:0]   cap_mask_s;
    logic [4*NDIG-1:0] slots_r;
    logic              frame_done_s;

    // Registered outputs
    logic [4*NDIG-1:0] value_r;
    logic              valid_r;
    logic              err_pattern_r;
    logic              err_anode_r;
    logic              overrun_r;

    // The counter compares the incoming sample with the registered one, so it
    // always states how many cycles the registered sample has been held.
    assign changed_s = ({seg_n, an_n} != {seg_r, an_r});

    // Input registers, change flag and saturating stability counter
    always_ff @(posedge clock) begin
        if (reset) begin
            seg_r     <= 7'h7F;
            an_r      <= {NDIG{1'b1}};
            cnt_r     <= {CW{1'b0}};
            changed_r <= 1'b0;
            an_bad_r  <= 1'b0;
        end else begin
            seg_r     <= seg_n;
            an_r      <= an_n;
            changed_r <= changed_s;
            an_bad_r  <= multi_s;
            if (changed_s) begin
                cnt_r <= CNT_ONE;
            end else if (cnt_r == CNT_MAX) begin
                cnt_r <= cnt_r;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    // Count active anodes and locate the (lowest) active one
    always_comb begin
        active_s  = ~an_r;
        low_cnt_s = 4'd0;
        idx_s     = {IW{1'b0}};
        for (int i = NDIG - 1; i >= 0; i--) begin
            low_cnt_s = low_cnt_s + {3'b000, active_s[i]};
            if (active_s[i]) begin
                idx_s = IW'(i);
            end else begin
                idx_s = idx_s;
            end
        end
        one_hot_s = (low_cnt_s == 4'd1);
        multi_s   = (low_cnt_s >= 4'd2);
    end

    sevenseg_match u_match (
        .pattern (seg_r),
        .hit     (hit_s),
        .nibble  (nibble_s)
    );

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state, capture strobe and pattern-error strobe
    always_comb begin
        state_next_s = state_r;
        cap_en_s     = 1'b0;
        err_pat_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (one_hot_s) begin
                    state_next_s = TRACK;
                end else begin
                    state_next_s = IDLE;
                end
            end
            TRACK: begin
                if (!one_hot_s) begin
                    state_next_s = IDLE;
                end else if (cnt_r == CNT_MAX) begin
                    if (hit_s) begin
                        cap_en_s = 1'b1;
                    end else begin
                        err_pat_s = 1'b1;
                    end
                    state_next_s = HELD;
                end else begin
                    state_next_s = TRACK;
                end
            end
            HELD: begin
                // Any sample change re-arms tracking; the latest stable value wins.
                if (!one_hot_s) begin
                    state_next_s = IDLE;
                end else if (changed_r) begin
                    state_next_s = TRACK;
                end else begin
                    state_next_s = HELD;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Frame completion and next capture mask; a completing frame clears the mask
    always_comb begin
        frame_done_s = &mask_r;
        for (int i = 0; i < NDIG; i++) begin
            cap_mask_s[i] = cap_en_s && (idx_s == IW'(i));
        end
        if (frame_done_s) begin
            mask_next_s = cap_mask_s;
        end else begin
            mask_next_s = mask_r | cap_mask_s;
        end
    end

    // Capture mask and digit slots
    always_ff @(posedge clock) begin
        if (reset) begin
            mask_r  <= {NDIG{1'b0}};
            slots_r <= {(4 * NDIG){1'b0}};
        end else begin
            mask_r <= mask_next_s;
            if (cap_en_s) begin
                slots_r[{idx_s, 2'b00} +: 4] <= nibble_s;
            end else begin
                slots_r <= slots_r;
            end
        end
    end

    // Output frame register with valid/ready handshake and sticky overrun
    always_ff @(posedge clock) begin
        if (reset) begin
            value_r   <= {(4 * NDIG){1'b0}};
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else if (frame_done_s) begin
            if (!valid_r || ready) begin
                value_r <= slots_r;
                valid_r <= 1'b1;
            end else begin
                overrun_r <= 1'b1;
            end
        end else if (valid_r && ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Error pulses; err_anode fires only on the first cycle of a multi-anode sample
    always_ff @(posedge clock) begin
        if (reset) begin
            err_pattern_r <= 1'b0;
            err_anode_r   <= 1'b0;
        end else begin
            err_pattern_r <= err_pat_s;
            err_anode_r   <= multi_s && !an_bad_r;
        end
    end

    assign value       = value_r;
    assign valid       = valid_r;
    assign err_pattern = err_pattern_r;
    assign err_anode   = err_anode_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_sevenseg_reader.sv
module tb_sevenseg_reader;

    localparam logic [3:0] AN0   = 4'b1110;
    localparam logic [3:0] AN1   = 4'b1101;
    localparam logic [3:0] AN2   = 4'b1011;
    localparam logic [3:0] AN3   = 4'b0111;
    localparam logic [3:0] BLANK = 4'b1111;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P6 = 7'b0000010;
    localparam logic [6:0] P7 = 7'b1111000;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0010000;
    localparam logic [6:0] PA = 7'b0001000;
    localparam logic [6:0] PB = 7'b0000011;
    localparam logic [6:0] PC = 7'b1000110;
    localparam logic [6:0] PD = 7'b0100001;
    localparam logic [6:0] PE = 7'b0000110;
    localparam logic [6:0] PF = 7'b0001110;
    localparam logic [6:0] PX = 7'b1111111;

    logic        clock;
    logic        reset;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic [15:0] value;
    logic        valid;
    logic        ready;
    logic        err_pattern;
    logic        err_anode;
    logic        overrun;

    int checks;
    int errors;
    int vcnt;
    int epc;
    int eac;
    logic [15:0] vlast;

    sevenseg_reader #(
        .NDIG          (4),
        .STABLE_CYCLES (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .value       (value),
        .valid       (valid),
        .ready       (ready),
        .err_pattern (err_pattern),
        .err_anode   (err_anode),
        .overrun     (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one sample for n cycles, observing outputs on each falling edge.
    task automatic hold(input logic [6:0] s, input logic [3:0] a, input int n);
        seg_n = s;
        an_n  = a;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            if (valid === 1'b1) begin
                vcnt++;
                vlast = value;
            end
            if (err_pattern === 1'b1) epc++;
            if (err_anode === 1'b1) eac++;
        end
    endtask

    task automatic clear_counts();
        vcnt  = 0;
        epc   = 0;
        eac   = 0;
        vlast = 16'h0000;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_counts();
        reset = 1'b1;
        ready = 1'b1;
        seg_n = PX;
        an_n  = BLANK;

        // Reset state
        hold(PX, BLANK, 3);
        chk("rst_value", {16'h0, value}, 32'h0000);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_err_pattern", {31'h0, err_pattern}, 32'h0);
        chk("rst_err_anode", {31'h0, err_anode}, 32'h0);
        chk("rst_overrun", {31'h0, overrun}, 32'h0);
        reset = 1'b0;
        hold(PX, BLANK, 2);

        // 1: basic frame, latency STABLE_CYCLES+2 on the last digit
        clear_counts();
        hold(P1, AN0, 6);
        hold(P2, AN1, 6);
        hold(PA, AN2, 6);
        hold(PF, AN3, 5);
        chk("t1_no_valid_early", vcnt, 0);
        hold(PF, AN3, 1);
        chk("t1_valid_at_latency", {31'h0, valid}, 32'h1);
        chk("t1_value", {16'h0, value}, 32'hFA21);
        hold(PX, BLANK, 3);
        chk("t1_valid_one_cycle", vcnt, 1);
        chk("t1_valid_dropped", {31'h0, valid}, 32'h0);

        // 2: overrun while consumer stalls
        clear_counts();
        ready = 1'b0;
        hold(P1, AN0, 6);
        hold(P2, AN1, 6);
        hold(PA, AN2, 6);
        hold(PF, AN3, 6);
        hold(PX, BLANK, 2);
        chk("t2_valid_held", {31'h0, valid}, 32'h1);
        chk("t2_overrun_clear", {31'h0, overrun}, 32'h0);
        hold(P8, AN0, 6);
        hold(P8, AN1, 6);
        hold(P8, AN2, 6);
        hold(P8, AN3, 6);
        hold(PX, BLANK, 3);
        chk("t2_value_kept", {16'h0, value}, 32'hFA21);
        chk("t2_valid_kept", {31'h0, valid}, 32'h1);
        chk("t2_overrun", {31'h0, overrun}, 32'h1);
        ready = 1'b1;
        hold(PX, BLANK, 1);
        chk("t2_valid_drop", {31'h0, valid}, 32'h0);
        chk("t2_overrun_sticky", {31'h0, overrun}, 32'h1);

        // 3: invalid pattern on digit 2, then rescan
        clear_counts();
        hold(P0, AN0, 6);
        hold(P1, AN1, 6);
        hold(PX, AN2, 6);
        hold(P5, AN3, 6);
        hold(PX, BLANK, 3);
        chk("t3_err_pattern_once", epc, 1);
        chk("t3_no_frame", vcnt, 0);
        hold(P3, AN2, 6);
        hold(PX, BLANK, 2);
        chk("t3_frame", vcnt, 1);
        chk("t3_value", {16'h0, vlast}, 32'h5310);
        chk("t3_digit2", {28'h0, vlast[11:8]}, 32'h3);

        // 4: two anodes low
        clear_counts();
        hold(P7, AN0, 6);
        hold(P9, AN1, 6);
        hold(P8, 4'b1100, 5);
        hold(PX, BLANK, 2);
        chk("t4_err_anode_once", eac, 1);
        chk("t4_no_frame", vcnt, 0);
        chk("t4_no_err_pattern", epc, 0);
        hold(PB, AN2, 6);
        hold(PD, AN3, 6);
        hold(PX, BLANK, 2);
        chk("t4_frame", vcnt, 1);
        chk("t4_value_mask_kept", {16'h0, vlast}, 32'hDB97);

        // 5: glitches and short patterns
        clear_counts();
        hold(P8, AN0, 2);
        hold(P0, AN0, 5);
        hold(P4, AN1, 6);
        hold(PE, AN2, 6);
        hold(P8, AN3, 3);
        hold(PX, BLANK, 4);
        chk("t5_short_not_captured", vcnt, 0);
        hold(PC, AN3, 6);
        hold(PX, BLANK, 2);
        chk("t5_frame", vcnt, 1);
        chk("t5_value", {16'h0, vlast}, 32'hCE40);

        // 6: reset mid-frame discards partial digits
        clear_counts();
        hold(P1, AN0, 6);
        hold(P2, AN1, 6);
        reset = 1'b1;
        hold(PX, BLANK, 2);
        chk("t6_rst_value", {16'h0, value}, 32'h0000);
        chk("t6_rst_valid", {31'h0, valid}, 32'h0);
        chk("t6_rst_overrun", {31'h0, overrun}, 32'h0);
        reset = 1'b0;
        clear_counts();
        hold(P7, AN2, 6);
        hold(P9, AN3, 6);
        hold(PX, BLANK, 3);
        chk("t6_partial_discarded", vcnt, 0);
        hold(P5, AN0, 6);
        hold(P6, AN1, 6);
        hold(PX, BLANK, 2);
        chk("t6_frame", vcnt, 1);
        chk("t6_value", {16'h0, vlast}, 32'h9765);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sevenseg_reader.md
Name: sevenseg_reader

Overview:
- Decodes a multiplexed, active-low seven-segment display bus back into hex digit values. It is the reader for the seven-segment decoder/scan driver path.
- Samples the segment lines and the one-hot active-low digit enables, requires each pattern to be stable before capturing it, and assembles a full frame of NDIG nibbles.
- Presents each completed frame on a valid/ready output handshake.
- Used in self-checking benches and in on-chip display loopback monitors.

Parameters:
- NDIG, 4, number of multiplexed digits (1..8)
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (>=1)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- seg_n  input  7  segment lines, active low; bit 6 = g ... bit 0 = a
- an_n  input  NDIG  digit enables, active low, expected one-hot-low or all-high (blank)
- value  output  4*NDIG  captured frame; digit k occupies value[4k+3:4k]
- valid  output  1  value holds an unconsumed frame
- ready  input  1  consumer accepts value when valid && ready
- err_pattern  output  1  one-cycle pulse: a stable pattern matched no hex code
- err_anode  output  1  one-cycle pulse: more than one an_n bit low
- overrun  output  1  sticky: a frame completed while valid && !ready

Behaviour:
- Reset, synchronous, active-high:
  - value=0, valid=0, err_pattern=0, err_anode=0, overrun=0.
  - Capture mask cleared, stability counter cleared, FSM to IDLE.
  - Reset asserted mid-frame discards the partial frame.
- Input stage: seg_n and an_n are registered once. All decisions use the registered copies, giving 1 cycle of input latency.
- Decode table, active low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - Any other pattern is invalid.
- Stability counter:
  - Reloads to 1 whenever the registered {seg_n, an_n} differs from the previous sample.
  - Otherwise increments, saturating at STABLE_CYCLES.
  - Width is $clog2(STABLE_CYCLES+1).
- FSM states IDLE, TRACK, HELD:
  - IDLE: an_n all high. Go to TRACK when exactly one an_n bit is low.
  - TRACK: when the counter reaches STABLE_CYCLES, decode the pattern.
    - Valid pattern: write the nibble into the digit slot of the active anode, set its mask bit, go to HELD.
    - Invalid pattern: pulse err_pattern for 1 cycle, go to HELD without capturing.
  - HELD: wait for any change of the sampled inputs.
    - Another single anode: go to TRACK.
    - All high: go to IDLE.
    - Pattern change on the same anode: go to TRACK and recapture. The latest stable value wins.
  - From any state, two or more an_n bits low: pulse err_anode once on entry, go to IDLE, capture nothing.
- Frame completion: in the cycle after the mask becomes all ones:
  - If !valid, or valid && ready: load value from the digit slots, set valid=1, clear the mask.
  - If valid && !ready: drop the frame, set overrun=1 (sticky until reset), clear the mask.
- Handshake:
  - valid and value stay stable until ready is high.
  - valid && ready with no new frame completing: valid drops next cycle.
  - Handshake and load in the same cycle: valid stays 1 and value updates (back-to-back).
- Latency: from a stable pattern on the last digit's first sample to valid=1 is STABLE_CYCLES+2 cycles.
- Digits may arrive in any order. Capturing the same digit twice before the frame completes keeps the later value.

Decomposition:
- Package sevenseg_pkg holds:
  - the 16-entry active-low pattern constant array, shared with the decoder;
  - the FSM state enum (IDLE, TRACK, HELD);
  - a function pattern_to_hex returning {valid_bit, nibble}.
- One sub-module, sevenseg_match: combinational pattern-to-nibble lookup using the package function. Everything else stays in sevenseg_reader.

Test Plan:
1. NDIG=4, STABLE_CYCLES=4. Scan digits 0..3 with patterns 1111001, 0100100, 0001000, 0001110, each held 6 cycles, ready=1 -> valid pulses with value=16'hFA21.
2. Same frame with ready=0, then a second frame of digits 8,8,8,8 -> value stays 16'hFA21, valid stays 1, overrun=1. Raising ready -> valid drops next cycle.
3. Digit 2 driven with 1111111 (invalid) for 6 cycles -> one err_pattern pulse; digit 2 not captured; no valid until digit 2 is rescanned with 0110000, then value[11:8]=3.
4. an_n=4'b1100 for 5 cycles -> one err_anode pulse, FSM to IDLE, mask unchanged.
5. Pattern glitch: digit 0 shows 0000000 for 2 cycles, then 1000000 for 5 cycles -> nibble 0 captured (not 8). A pattern held only STABLE_CYCLES-1 cycles is never captured.
6. Reset asserted after 2 of 4 digits captured, then a full frame 5,6,7,9 -> value=16'h9765; the earlier digits do not appear.
